// File: rtl/dsp_filter_pkg.sv
`default_nettype none
// ============================================================================
// Module   : dsp_filter_pkg
// Purpose  : Shared helpers for the DSP filter chain: accumulator width,
//            rounding offset and the largest supported window exponent.
// Ports    : none (package)
// Revision : 1.0 - initial release
// ============================================================================
package dsp_filter_pkg;

  // Largest supported log2 of a moving-average window (N = 256).
  localparam int MAX_LOG2_LEN = 8;

  // A sum of 2**log2_len samples of data_w bits needs log2_len extra bits.
  function automatic int acc_w(input int data_w, input int log2_len);
    return data_w + log2_len;
  endfunction

  // Half of one output LSB after the divide by 2**log2_len (round half up).
  function automatic int round_offset(input int log2_len);
    return (log2_len > 0) ? (1 << (log2_len - 1)) : 0;
  endfunction

endpackage : dsp_filter_pkg
`default_nettype wire

// File: rtl/moving_average_filter_if.sv
`default_nettype none
// ============================================================================
// Module   : moving_average_filter_if
// Purpose  : Clock-enable streaming bundle between a sample source and the
//            moving-average filter.
// Signals  : i_ce      sample strobe (source -> filter)
//            i_clear   synchronous flush (source -> filter)
//            data_in   unsigned sample (source -> filter)
//            data_out  registered window average (filter -> source)
//            o_ce      one-cycle output strobe (filter -> source)
//            o_primed  window fully populated (filter -> source)
// Modports : master (source side), slave (filter side)
// Revision : 1.0 - initial release
// ============================================================================
interface moving_average_filter_if #(
  parameter int DATA_W = 8
);
  logic              i_ce;
  logic              i_clear;
  logic [DATA_W-1:0] data_in;
  logic [DATA_W-1:0] data_out;
  logic              o_ce;
  logic              o_primed;

  modport master (
    output i_ce, i_clear, data_in,
    input  data_out, o_ce, o_primed
  );

  modport slave (
    input  i_ce, i_clear, data_in,
    output data_out, o_ce, o_primed
  );
endinterface : moving_average_filter_if
`default_nettype wire

// File: rtl/moving_average_delay_line.sv
`default_nettype none
// ============================================================================
// Module   : moving_average_delay_line
// Purpose  : 2**LOG2_LEN deep circular buffer. rd_data is always the entry
//            at the write pointer, i.e. the oldest sample, which is the one
//            about to be overwritten by the next write.
// Ports    : clk      in   system clock, rising edge
//            reset    in   asynchronous active-high reset
//            clear    in   synchronous flush of all entries and pointer
//            wr_en    in   write wr_data and advance the pointer
//            wr_data  in   DATA_W sample to store
//            rd_data  out  DATA_W oldest entry
// Revision : 1.0 - initial release
// ============================================================================
module moving_average_delay_line #(
  parameter int DATA_W   = 8,
  parameter int LOG2_LEN = 2
) (
  input  wire logic              clk,
  input  wire logic              reset,
  input  wire logic              clear,
  input  wire logic              wr_en,
  input  wire logic [DATA_W-1:0] wr_data,
  output logic      [DATA_W-1:0] rd_data
);
  localparam int c_DEPTH = 1 << LOG2_LEN;

  logic [DATA_W-1:0]   r_mem [c_DEPTH];
  logic [LOG2_LEN-1:0] r_wptr;

  // The pointer width equals log2 of the depth, so the increment wraps
  // from N-1 to 0 naturally.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_wptr <= '0;
      for (int i = 0; i < c_DEPTH; i++) r_mem[i] <= '0;
    end else if (clear) begin
      // Parallel clear so a flush takes effect in a single cycle.
      r_wptr <= '0;
      for (int i = 0; i < c_DEPTH; i++) r_mem[i] <= '0;
    end else if (wr_en) begin
      r_mem[r_wptr] <= wr_data;
      r_wptr        <= r_wptr + 1'b1;
    end
  end

  assign rd_data = r_mem[r_wptr];

endmodule : moving_average_delay_line
`default_nettype wire

// File: rtl/moving_average_filter.sv
`default_nettype none
// ============================================================================
// Module   : moving_average_filter
// Purpose  : Boxcar moving average over the last 2**LOG2_LEN accepted
//            samples, using a running-sum accumulator and a circular delay
//            line. One clock of latency, full throughput, no backpressure.
// Ports    : clk    in      system clock, rising edge
//            reset  in      asynchronous active-high reset
//            bus    slave   streaming bundle (i_ce, i_clear, data_in,
//                           data_out, o_ce, o_primed)
// Options  : MOVING_AVERAGE_FILTER_ROUND_EN - when defined, the average is
//            rounded half up (saturating); otherwise it is truncated.
// Revision : 1.0 - initial release
// ============================================================================
module moving_average_filter
  import dsp_filter_pkg::*;
#(
  parameter int DATA_W   = 8,
  parameter int LOG2_LEN = 2
) (
  input  wire logic              clk,
  input  wire logic              reset,
  moving_average_filter_if.slave bus
);
  localparam int                 c_ACC_W = acc_w(DATA_W, LOG2_LEN);
  localparam int                 c_N     = 1 << LOG2_LEN;
  localparam logic [LOG2_LEN:0]  c_FULL  = (LOG2_LEN+1)'(c_N);

  logic [c_ACC_W-1:0] r_acc;
  logic [LOG2_LEN:0]  r_fill;
  logic [DATA_W-1:0]  r_data_out;
  logic               r_o_ce;
  logic               r_primed;

  logic               w_take;
  logic [DATA_W-1:0]  w_old;
  logic [c_ACC_W-1:0] w_acc_next;
  logic [LOG2_LEN:0]  w_fill_next;
  logic [DATA_W-1:0]  w_avg;

  // Clear wins over a simultaneous sample.
  assign w_take = bus.i_ce & ~bus.i_clear;

  moving_average_delay_line #(
    .DATA_W   (DATA_W),
    .LOG2_LEN (LOG2_LEN)
  ) u_delay (
    .clk     (clk),
    .reset   (reset),
    .clear   (bus.i_clear),
    .wr_en   (w_take),
    .wr_data (bus.data_in),
    .rd_data (w_old)
  );

  // The accumulator always equals the sum of the delay-line contents, so
  // subtracting the oldest entry first can never go negative.
  assign w_acc_next = (r_acc - c_ACC_W'(w_old)) + c_ACC_W'(bus.data_in);

  assign w_fill_next = (r_fill == c_FULL) ? r_fill : r_fill + 1'b1;

`ifdef MOVING_AVERAGE_FILTER_ROUND_EN
  localparam logic [c_ACC_W:0] c_RND_OFF = (c_ACC_W+1)'(round_offset(LOG2_LEN));

  logic [c_ACC_W:0] w_rnd;

  // One guard bit above the accumulator holds any carry from the offset.
  assign w_rnd = {1'b0, w_acc_next} + c_RND_OFF;

  always_comb begin
    w_avg = DATA_W'(w_rnd >> LOG2_LEN);
    if (w_rnd[c_ACC_W]) w_avg = '1;
  end
`else
  assign w_avg = DATA_W'(w_acc_next >> LOG2_LEN);
`endif

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_acc      <= '0;
      r_fill     <= '0;
      r_data_out <= '0;
      r_o_ce     <= 1'b0;
      r_primed   <= 1'b0;
    end else if (bus.i_clear) begin
      r_acc      <= '0;
      r_fill     <= '0;
      r_data_out <= '0;
      r_o_ce     <= 1'b0;
      r_primed   <= 1'b0;
    end else if (bus.i_ce) begin
      r_acc      <= w_acc_next;
      r_fill     <= w_fill_next;
      r_data_out <= w_avg;
      r_o_ce     <= 1'b1;
      r_primed   <= (w_fill_next == c_FULL);
    end else begin
      r_o_ce     <= 1'b0;
    end
  end

  assign bus.data_out = r_data_out;
  assign bus.o_ce     = r_o_ce;
  assign bus.o_primed = r_primed;

endmodule : moving_average_filter
`default_nettype wire

// File: tb/tb_moving_average_filter.sv
`default_nettype none
// ============================================================================
// Module   : tb_moving_average_filter
// Purpose  : Self-checking bench for moving_average_filter (DATA_W=8,
//            LOG2_LEN=2). Directed cases followed by random stimulus, all
//            compared with a window-sum reference model.
// Options  : honours MOVING_AVERAGE_FILTER_ROUND_EN in its reference model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_moving_average_filter;
  localparam int DW = 8;
  localparam int L2 = 2;
  localparam int N  = 1 << L2;

  logic clk;
  logic reset;

  moving_average_filter_if #(.DATA_W(DW)) bus ();

  moving_average_filter #(
    .DATA_W   (DW),
    .LOG2_LEN (L2)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  // Reference model: the accepted samples still inside the window.
  int win[$];
  int filled  = 0;
  int exp_out = 0;
  int exp_ce  = 0;

  task automatic check_value(input string tag, input logic [31:0] obs,
                             input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, obs, exp, $time);
    end
  endtask

  function automatic int model_avg();
    int sum = 0;
    int r;
    foreach (win[i]) sum += win[i];
`ifdef MOVING_AVERAGE_FILTER_ROUND_EN
    r = (sum + N / 2) / N;
    if (r > (1 << DW) - 1) r = (1 << DW) - 1;
`else
    r = sum / N;
`endif
    return r;
  endfunction

  task automatic model_reset();
    win.delete();
    filled  = 0;
    exp_out = 0;
    exp_ce  = 0;
  endtask

  task automatic check_outputs(input string where);
    check_value({where, ".data_out"}, 32'(bus.data_out), 32'(exp_out));
    check_value({where, ".o_ce"},     32'(bus.o_ce),     32'(exp_ce));
    check_value({where, ".o_primed"}, 32'(bus.o_primed), 32'(filled == N));
  endtask

  // Drive one cycle of stimulus, update the model, check after the edge.
  task automatic step(input bit ce, input bit clr, input int d, input string tag);
    logic [31:0] dv;
    dv = 32'(d);
    @(negedge clk);
    bus.i_ce    = ce;
    bus.i_clear = clr;
    bus.data_in = dv[DW-1:0];
    @(posedge clk);
    #1;
    if (clr) begin
      model_reset();
    end else if (ce) begin
      win.push_back(d);
      if (win.size() > N) void'(win.pop_front());
      exp_out = model_avg();
      exp_ce  = 1;
      if (filled < N) filled++;
    end else begin
      exp_ce = 0;
    end
    check_outputs(tag);
  endtask

  initial begin
    bus.i_ce    = 1'b0;
    bus.i_clear = 1'b0;
    bus.data_in = '0;
    reset       = 1'b1;
    model_reset();
    repeat (3) @(posedge clk);
    #1;
    check_outputs("reset");
    @(negedge clk);
    reset = 1'b0;

    // Ramp: 4,8,12,16 -> 1,3,6,10 with priming on the fourth.
    step(1, 0, 4,  "ramp");
    step(1, 0, 8,  "ramp");
    step(1, 0, 12, "ramp");
    step(1, 0, 16, "ramp");
    step(0, 0, 0,  "ramp_idle");

    // Full-scale run, then drain to zero.
    for (int i = 0; i < 8; i++) step(1, 0, 255, "full");
    for (int i = 0; i < 4; i++) step(1, 0, 0, "drain");

    // Sparse strobes: data_out holds between samples.
    step(0, 1, 0, "clr");
    for (int i = 0; i < 4; i++) begin
      step(1, 0, 40, "sparse");
      for (int j = 0; j < 3; j++) step(0, 0, 0, "sparse_idle");
    end

    // Clear wins over a simultaneous sample.
    step(1, 1, 200, "clr_ce");
    step(1, 0, 100, "after_clr");

    // Rounding probe: 2,0,0,0 (first output 1 rounded, 0 truncated).
    step(0, 1, 0, "clr2");
    step(1, 0, 2, "rnd");
    step(1, 0, 0, "rnd");
    step(1, 0, 0, "rnd");
    step(1, 0, 0, "rnd");

    // Asynchronous reset between edges, mid-stream.
    for (int i = 0; i < 5; i++) step(1, 0, 60 + i, "pre_rst");
    #2;
    reset = 1'b1;
    #1;
    model_reset();
    check_outputs("async_rst");
    reset = 1'b0;
    step(1, 0, 8, "post_rst");

    // Random stimulus.
    for (int i = 0; i < 400; i++) begin
      automatic int r = $urandom_range(0, 99);
      automatic int d = (r < 10) ? 255 : $urandom_range(0, 255);
      step(r < 70, r >= 97, d, "rand");
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

  // Guard against a stalled run.
  initial begin
    #200000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1, "timeout");
  end

endmodule : tb_moving_average_filter
`default_nettype wire
